// File: rtl/ftb_update_encoder.sv
`default_nettype none
// ============================================================================
// Module  : ftb_update_encoder
// Purpose : Compresses resolved fetch blocks into FTB entry encoding and
//           queues them for the FTB write port.
// Revision: 1.0
// ============================================================================
module ftb_update_encoder #(
  parameter  int XLEN       = 64,
  parameter  int FALLTHRU_W = 4,
  parameter  int TARGET_W   = 4,
  parameter  int BT_W       = 3,
  parameter  int DEPTH      = 4,
  localparam int UPD_W      = XLEN + BT_W + FALLTHRU_W + TARGET_W + 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_vld,
  output logic              o_rdy,
  input  logic [XLEN-1:0]   i_startAddr,
  input  logic [XLEN-1:0]   i_endAddr,
  input  logic              i_taken,
  input  logic [XLEN-1:0]   i_targetAddr,
  input  logic [BT_W-1:0]   i_branch_type,
  input  logic              i_hit_on_ftb,
  input  logic [1:0]        i_ftb_counter,
  output logic              o_upd_vld,
  input  logic              i_upd_rdy,
  output logic [UPD_W-1:0]  o_upd,
  output logic [15:0]       o_drop_cnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int FHW = XLEN - FALLTHRU_W - 1;
  localparam int THW = XLEN - TARGET_W - 1;
  localparam logic [1:0] TAR_FIT = 2'd0;
  localparam logic [1:0] TAR_OVF = 2'd1;
  localparam logic [1:0] TAR_UDF = 2'd2;

  logic              s1_vld;
  logic [XLEN-1:0]   s1_start;
  logic [XLEN-1:1]   s1_end;
  logic [XLEN-1:1]   s1_tgt;
  logic              s1_taken;
  logic              s1_hit;
  logic [BT_W-1:0]   s1_bt;
  logic [1:0]        s1_cnt;

  logic [UPD_W-1:0]  mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              push;
  logic              accept;
  logic              drop;
  logic              unenc;

  logic [FHW-1:0]    s_fh;
  logic [FHW-1:0]    e_fh;
  logic [THW-1:0]    s_th;
  logic [THW-1:0]    t_th;
  logic              car_ok;
  logic              tar_ok;
  logic              carry;
  logic [1:0]        tar_stat;
  logic [TARGET_W-1:0] tar_fld;
  logic [1:0]        new_cnt;
  logic [UPD_W-1:0]  enc;
  logic              unused_bit0;

  // Bit 0 of the end and target PCs carries no information.
  assign unused_bit0 = ^{i_endAddr[0], i_targetAddr[0]};

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_upd_vld  = !fifo_empty;
  assign pop        = o_upd_vld && i_upd_rdy;
  assign o_rdy      = !s1_vld || !fifo_full || pop;
  assign accept     = i_vld && o_rdy;
  assign o_upd      = o_upd_vld ? mem[rd_ptr[AW-1:0]] : '0;

  always_comb begin
    s_fh     = s1_start[XLEN-1:FALLTHRU_W+1];
    e_fh     = s1_end[XLEN-1:FALLTHRU_W+1];
    s_th     = s1_start[XLEN-1:TARGET_W+1];
    t_th     = s1_tgt[XLEN-1:TARGET_W+1];
    car_ok   = 1'b1;
    carry    = 1'b0;
    tar_ok   = 1'b1;
    tar_stat = TAR_FIT;
    tar_fld  = '0;
    new_cnt  = 2'd1;

    // High-part deltas wrap modulo their own width, so address-space wrap encodes.
    if (e_fh == s_fh)                carry  = 1'b0;
    else if (e_fh == s_fh + FHW'(1)) carry  = 1'b1;
    else                             car_ok = 1'b0;

    if (s1_taken) begin
      tar_fld = s1_tgt[TARGET_W:1];
      if (t_th == s_th)                tar_stat = TAR_FIT;
      else if (t_th == s_th + THW'(1)) tar_stat = TAR_OVF;
      else if (t_th == s_th - THW'(1)) tar_stat = TAR_UDF;
      else                             tar_ok   = 1'b0;
    end

    if (s1_hit) begin
      if (s1_taken) new_cnt = (s1_cnt == 2'd3) ? 2'd3 : s1_cnt + 2'd1;
      else          new_cnt = (s1_cnt == 2'd0) ? 2'd0 : s1_cnt - 2'd1;
    end else begin
      new_cnt = s1_taken ? 2'd2 : 2'd1;
    end

    enc = {s1_start, s1_bt, carry, s1_end[FALLTHRU_W:1], tar_stat, tar_fld, new_cnt};
  end

  assign unenc = !(car_ok && tar_ok);
  assign drop  = s1_vld && unenc && !i_flush;
  assign push  = s1_vld && !unenc && (!fifo_full || pop) && !i_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld   <= 1'b0;
      s1_start <= '0;
      s1_end   <= '0;
      s1_tgt   <= '0;
      s1_taken <= 1'b0;
      s1_hit   <= 1'b0;
      s1_bt    <= '0;
      s1_cnt   <= '0;
    end else if (i_flush) begin
      s1_vld <= 1'b0;
    end else if (accept) begin
      s1_vld   <= 1'b1;
      s1_start <= i_startAddr;
      s1_end   <= i_endAddr[XLEN-1:1];
      s1_tgt   <= i_targetAddr[XLEN-1:1];
      s1_taken <= i_taken;
      s1_hit   <= i_hit_on_ftb;
      s1_bt    <= i_branch_type;
      s1_cnt   <= i_ftb_counter;
    end else if (push || drop) begin
      s1_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= enc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              o_drop_cnt <= '0;
    else if (drop && o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
  end

endmodule
`default_nettype wire

// File: tb/tb_ftb_update_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_ftb_update_encoder
// Purpose : Directed vector bench for ftb_update_encoder.
// Revision: 1.0
// ============================================================================
module tb_ftb_update_encoder;

  localparam int XLEN = 64;
  localparam int UW   = 80;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_flush, i_vld, o_rdy, i_taken, i_hit_on_ftb;
  logic [63:0]   i_startAddr, i_endAddr, i_targetAddr;
  logic [2:0]    i_branch_type;
  logic [1:0]    i_ftb_counter;
  logic          o_upd_vld, i_upd_rdy;
  logic [UW-1:0] o_upd;
  logic [15:0]   o_drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_drop = 0;

  always #5 clk = ~clk;

  ftb_update_encoder #(.XLEN(XLEN), .FALLTHRU_W(4), .TARGET_W(4), .BT_W(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_vld(i_vld), .o_rdy(o_rdy),
    .i_startAddr(i_startAddr), .i_endAddr(i_endAddr), .i_taken(i_taken),
    .i_targetAddr(i_targetAddr), .i_branch_type(i_branch_type),
    .i_hit_on_ftb(i_hit_on_ftb), .i_ftb_counter(i_ftb_counter),
    .o_upd_vld(o_upd_vld), .i_upd_rdy(i_upd_rdy), .o_upd(o_upd), .o_drop_cnt(o_drop_cnt)
  );

  typedef struct {
    logic [63:0] st;
    logic [63:0] en;
    logic        tk;
    logic [63:0] tg;
    logic [2:0]  bt;
    logic        hit;
    logic [1:0]  cn;
    logic        drop;
    logic        car;
    logic [3:0]  ft;
    logic [1:0]  ts;
    logic [3:0]  ta;
    logic [1:0]  ec;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [UW-1:0] act, input logic [UW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [UW-1:0] pk(input logic [63:0] st, input logic [2:0] bt, input logic car,
                                       input logic [3:0] ft, input logic [1:0] ts,
                                       input logic [3:0] ta, input logic [1:0] ec);
    return {st, bt, car, ft, ts, ta, ec};
  endfunction

  function automatic logic [UW-1:0] bp_exp(input int j);
    return pk(64'h4000 + 64'(j) * 64'h20, 3'(j), 1'b0, 4'h8, 2'd0, 4'h0, 2'd1);
  endfunction

  task automatic drive(input vec_t v);
    i_startAddr   = v.st;
    i_endAddr     = v.en;
    i_taken       = v.tk;
    i_targetAddr  = v.tg;
    i_branch_type = v.bt;
    i_hit_on_ftb  = v.hit;
    i_ftb_counter = v.cn;
  endtask

  task automatic drive_bp(input int k);
    i_startAddr   = 64'h4000 + 64'(k) * 64'h20;
    i_endAddr     = i_startAddr + 64'h10;
    i_taken       = 1'b0;
    i_targetAddr  = 64'h0;
    i_branch_type = 3'(k);
    i_hit_on_ftb  = 1'b0;
    i_ftb_counter = 2'd0;
  endtask

  task automatic send(input vec_t v);
    @(negedge clk);
    drive(v);
    i_vld = 1'b1;
    @(posedge clk);
    #1 i_vld = 1'b0;
  endtask

  // Streams 8 cycles of back-to-back inputs against a stalled sink; returns accepts.
  task automatic fill(output int k);
    logic rdy_s;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive_bp(k);
      i_vld = 1'b1;
      rdy_s = o_rdy;
      @(posedge clk);
      if (rdy_s) k++;
    end
    #1 i_vld = 1'b0;
  endtask

  initial begin
    int   k;
    logic seen;

    rst = 1'b0; i_flush = 1'b0; i_vld = 1'b0; i_upd_rdy = 1'b1;
    i_startAddr = '0; i_endAddr = '0; i_taken = 1'b0; i_targetAddr = '0;
    i_branch_type = '0; i_hit_on_ftb = 1'b0; i_ftb_counter = '0;

    //          st                     en                     tk    tg                     bt    hit   cn    drop  car   ft     ts    ta     ec
    vecs[0] = '{64'h1000,              64'h1010,              1'b1, 64'h1008,              3'd1, 1'b1, 2'd2, 1'b0, 1'b0, 4'h8, 2'd0, 4'h4, 2'd3};
    vecs[1] = '{64'h1000,              64'h1020,              1'b1, 64'h0FF0,              3'd2, 1'b0, 2'd0, 1'b0, 1'b1, 4'h0, 2'd2, 4'h8, 2'd2};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFE0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 64'h0,          3'd3, 1'b1, 2'd3, 1'b0, 1'b0, 4'h8, 2'd1, 4'h0, 2'd3};
    vecs[3] = '{64'h1000,              64'h1010,              1'b1, 64'h2000,              3'd1, 1'b1, 2'd2, 1'b1, 1'b0, 4'h0, 2'd0, 4'h0, 2'd0};
    vecs[4] = '{64'h1000,              64'h1010,              1'b0, 64'h2000,              3'd1, 1'b1, 2'd0, 1'b0, 1'b0, 4'h8, 2'd0, 4'h0, 2'd0};
    vecs[5] = '{64'h1000,              64'h1040,              1'b0, 64'h0,                 3'd0, 1'b0, 2'd0, 1'b1, 1'b0, 4'h0, 2'd0, 4'h0, 2'd0};
    vecs[6] = '{64'h101E,              64'h1022,              1'b0, 64'h5555,              3'd5, 1'b0, 2'd0, 1'b0, 1'b1, 4'h1, 2'd0, 4'h0, 2'd1};
    vecs[7] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'h4,               1'b1, 64'hFFFF_FFFF_FFFF_FFC0, 3'd7, 1'b1, 2'd1, 1'b0, 1'b1, 4'h2, 2'd2, 4'h0, 2'd2};
    vecs[8] = '{64'h2000,              64'h2002,              1'b0, 64'h0,                 3'd0, 1'b1, 2'd2, 1'b0, 1'b0, 4'h1, 2'd0, 4'h0, 2'd1};
    vecs[9] = '{64'h0,                 64'h0A,                1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 3'd4, 1'b0, 2'd3, 1'b0, 1'b0, 4'h5, 2'd2, 4'hF, 2'd2};

    // Reset state
    repeat (2) @(negedge clk);
    chkb("rst_upd_vld", o_upd_vld, 1'b0);
    chkb("rst_rdy", o_rdy, 1'b1);
    chk16("rst_drop_cnt", o_drop_cnt, 16'd0);
    chk("rst_upd", o_upd, '0);
    rst = 1'b1;

    // Table vectors: two-cycle latency, encoding and drop accounting
    for (int i = 0; i < 10; i++) begin
      send(vecs[i]);
      @(negedge clk);
      chkb($sformatf("v%0d_latency", i), o_upd_vld, 1'b0);
      @(negedge clk);
      chkb($sformatf("v%0d_upd_vld", i), o_upd_vld, !vecs[i].drop);
      if (!vecs[i].drop)
        chk($sformatf("v%0d_upd", i), o_upd,
            pk(vecs[i].st, vecs[i].bt, vecs[i].car, vecs[i].ft, vecs[i].ts, vecs[i].ta, vecs[i].ec));
      if (vecs[i].drop) exp_drop++;
      chk16($sformatf("v%0d_drop_cnt", i), o_drop_cnt, 16'(exp_drop));
    end

    // Backpressure: 4 in FIFO + 1 in S1, head held, then drained in order
    @(negedge clk);
    i_upd_rdy = 1'b0;
    fill(k);
    @(negedge clk);
    chkb("bp_accepts_5", k == 5, 1'b1);
    chkb("bp_rdy_low", o_rdy, 1'b0);
    chkb("bp_upd_vld", o_upd_vld, 1'b1);
    for (int h = 0; h < 3; h++) begin
      chk($sformatf("bp_hold%0d", h), o_upd, bp_exp(0));
      @(negedge clk);
    end
    i_upd_rdy = 1'b1;
    for (int j = 0; j < 5; j++) begin
      chkb($sformatf("bp_drain_vld%0d", j), o_upd_vld, 1'b1);
      chk($sformatf("bp_drain%0d", j), o_upd, bp_exp(j));
      @(negedge clk);
    end
    chkb("bp_drained_empty", o_upd_vld, 1'b0);

    // Flush with S1 and FIFO full and a valid input in the flush cycle
    i_upd_rdy = 1'b0;
    fill(k);
    chkb("fl_accepts_5", k == 5, 1'b1);
    @(negedge clk);
    i_startAddr = 64'hDEAD_0000; i_endAddr = 64'hDEAD_0010; i_taken = 1'b0;
    i_vld = 1'b1; i_flush = 1'b1;
    @(posedge clk);
    #1 i_vld = 1'b0; i_flush = 1'b0;
    @(negedge clk);
    chkb("fl_upd_vld", o_upd_vld, 1'b0);
    chkb("fl_rdy", o_rdy, 1'b1);
    chk16("fl_drop_kept", o_drop_cnt, 16'(exp_drop));
    i_upd_rdy = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (o_upd_vld) seen = 1'b1;
    end
    chkb("fl_nothing_emitted", seen, 1'b0);

    // Asynchronous reset with three entries queued
    i_upd_rdy = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      drive_bp(j);
      i_vld = 1'b1;
      @(posedge clk);
      #1 i_vld = 1'b0;
    end
    @(posedge clk);
    #1;
    chkb("mr_pre_vld", o_upd_vld, 1'b1);
    chk("mr_pre_head", o_upd, bp_exp(0));
    rst = 1'b0;
    #1;
    chkb("mr_upd_vld", o_upd_vld, 1'b0);
    chkb("mr_rdy", o_rdy, 1'b1);
    chk16("mr_drop_cnt", o_drop_cnt, 16'd0);
    chk("mr_upd", o_upd, '0);
    @(negedge clk);
    rst = 1'b1;
    i_upd_rdy = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (o_upd_vld) seen = 1'b1;
    end
    chkb("mr_nothing_after", seen, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
